// File: rtl/coin_seq_pkg.sv
// Shared types and default frame counts for the coin/start pulse sequencer.
// No configuration macros are used in this file.
package coin_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COIN,
        GAP,
        START,
        RELEASE
    } coin_seq_state_t;

    localparam int DEF_COIN_FRAMES  = 3;
    localparam int DEF_GAP_FRAMES   = 6;
    localparam int DEF_START_FRAMES = 3;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/coin_start_sequencer_if.sv
// Request/pulse bundle between the player-input front end and the sequencer.
// Optional macro COIN_SEQ_DIRECT_COIN_EN adds the coin_req line.
interface coin_start_sequencer_if;

`ifdef COIN_SEQ_DIRECT_COIN_EN
    logic coin_req;
`endif
    logic vblank;
    logic start1_req;
    logic start2_req;
    logic coin_n;
    logic start1_n;
    logic start2_n;
    logic busy;

    // master: the request source; slave: the sequencer itself
    modport master (
`ifdef COIN_SEQ_DIRECT_COIN_EN
        output coin_req,
`endif
        output vblank,
        output start1_req,
        output start2_req,
        input  coin_n,
        input  start1_n,
        input  start2_n,
        input  busy
    );

    modport slave (
`ifdef COIN_SEQ_DIRECT_COIN_EN
        input  coin_req,
`endif
        input  vblank,
        input  start1_req,
        input  start2_req,
        output coin_n,
        output start1_n,
        output start2_n,
        output busy
    );

endinterface

// File: rtl/coin_start_sequencer_vblank_tick.sv
// Rising-edge strobe on VBLANK: one clk-wide tick per frame.
// No configuration macros are used in this file.
module vblank_tick (
    input  logic clk,
    input  logic rst_n,
    input  logic vblank,
    output logic tick
);

    logic vblank_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vblank_q <= 1'b0;
        end else begin
            vblank_q <= vblank;
        end
    end

    assign tick = vblank & ~vblank_q;

endmodule

// File: rtl/coin_start_sequencer.sv
// Converts 1P/2P start intent into frame-timed coin-then-start pulses.
// Optional macro COIN_SEQ_DIRECT_COIN_EN adds a coin-only request path.
module coin_start_sequencer
    import coin_seq_pkg::*;
#(
    parameter int COIN_FRAMES  = DEF_COIN_FRAMES,
    parameter int GAP_FRAMES   = DEF_GAP_FRAMES,
    parameter int START_FRAMES = DEF_START_FRAMES
) (
    input  logic                   clk_sys,
    input  logic                   RESET_N,
    coin_start_sequencer_if.slave  io
);

    localparam int CNT_W = $clog2(max3(COIN_FRAMES, GAP_FRAMES, START_FRAMES) + 1);
    localparam logic [CNT_W-1:0] COIN_LAST  = CNT_W'(COIN_FRAMES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_FRAMES - 1);
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_FRAMES - 1);

    coin_seq_state_t  state, next_state;
    logic [CNT_W-1:0] frame_cnt;
    logic [1:0]       credits_left, credits_nxt;
    logic             sel2, sel2_nxt;      // 0 selects start 1, 1 selects start 2
    logic             no_start, no_start_nxt;
    logic             tick;
    logic             coin_q, start1_q, start2_q, busy_q;
    logic             any_req;

    vblank_tick u_tick (
        .clk    (clk_sys),
        .rst_n  (RESET_N),
        .vblank (io.vblank),
        .tick   (tick)
    );

`ifdef COIN_SEQ_DIRECT_COIN_EN
    // A held coin request must also be released, or it would re-trigger.
    assign any_req = io.start1_req | io.start2_req | io.coin_req;
`else
    assign any_req = io.start1_req | io.start2_req;
    assign no_start_nxt = 1'b0;
`endif

    // NOTE: every variable gets a default before the case, so no latches are inferred.
    always_comb begin
        next_state  = state;
        credits_nxt = credits_left;
        sel2_nxt    = sel2;
`ifdef COIN_SEQ_DIRECT_COIN_EN
        no_start_nxt = no_start;
`endif
        case (state)
            IDLE: begin
                if (io.start2_req) begin
                    next_state  = COIN;
                    credits_nxt = 2'd2;
                    sel2_nxt    = 1'b1;
`ifdef COIN_SEQ_DIRECT_COIN_EN
                    no_start_nxt = 1'b0;
`endif
                end else if (io.start1_req) begin
                    next_state  = COIN;
                    credits_nxt = 2'd1;
                    sel2_nxt    = 1'b0;
`ifdef COIN_SEQ_DIRECT_COIN_EN
                    no_start_nxt = 1'b0;
                end else if (io.coin_req) begin
                    next_state   = COIN;
                    credits_nxt  = 2'd1;
                    no_start_nxt = 1'b1;
`endif
                end
            end
            COIN: begin
                if (tick && frame_cnt == COIN_LAST) begin
                    next_state  = GAP;
                    credits_nxt = credits_left - 2'd1;
                end
            end
            GAP: begin
                if (tick && frame_cnt == GAP_LAST) begin
                    if (credits_left != 2'd0) begin
                        next_state = COIN;
                    end else if (no_start) begin
                        next_state = RELEASE;
                    end else begin
                        next_state = START;
                    end
                end
            end
            START: begin
                if (tick && frame_cnt == START_LAST) begin
                    next_state = RELEASE;
                end
            end
            RELEASE: begin
                if (!any_req) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; the async reset
    // drives every output inactive at once, aborting any pulse mid-frame.
    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            state        <= IDLE;
            frame_cnt    <= '0;
            credits_left <= 2'd0;
            sel2         <= 1'b0;
            coin_q       <= 1'b1;
            start1_q     <= 1'b1;
            start2_q     <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state        <= next_state;
            credits_left <= credits_nxt;
            sel2         <= sel2_nxt;
            if (next_state != state) begin
                frame_cnt <= '0;
            end else if (tick && (state == COIN || state == GAP || state == START)) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
            // Outputs decode next_state so they move on the same edge as the state.
            coin_q   <= (next_state != COIN);
            start1_q <= !(next_state == START && !sel2_nxt);
            start2_q <= !(next_state == START && sel2_nxt);
            busy_q   <= (next_state != IDLE);
        end
    end

`ifdef COIN_SEQ_DIRECT_COIN_EN
    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            no_start <= 1'b0;
        end else begin
            no_start <= no_start_nxt;
        end
    end
`else
    assign no_start = 1'b0;
`endif

    assign io.coin_n   = coin_q;
    assign io.start1_n = start1_q;
    assign io.start2_n = start2_q;
    assign io.busy     = busy_q;

endmodule

// File: doc/coin_start_sequencer.md
# coin_start_sequencer

Turns a player's "start" intent (joystick Start button or F1/F2 key) into the coin-then-start pulse sequence the Ms. Pac-Man core expects on its active-low `in0_reg`/`in1_reg` bits. It replaces the direct `coin = start1 | start2` wiring. The outputs use frame-length pulses counted on VBLANK, so the game CPU's input poll always sees each pulse, including the two credits needed for a 2-player start.

## Interface
Parameters:
- `COIN_FRAMES`, 3, frames the coin line is held active per credit (≥1)
- `GAP_FRAMES`, 6, inactive frames after each coin pulse (≥1)
- `START_FRAMES`, 3, frames the selected start line is held active (≥1)

Ports:
- `clk_sys`  in  1  system clock; all logic on its rising edge
- `RESET_N`  in  1  asynchronous, active-low reset
- `vblank`  in  1  core VBLANK, already in the `clk_sys` domain
- `start1_req`  in  1  active-high, level: 1P start requested
- `start2_req`  in  1  active-high, level: 2P start requested
- `coin_n`  out  1  active-low coin, to `in0_reg` bit 5
- `start1_n`  out  1  active-low start 1, to `in1_reg` bit 5
- `start2_n`  out  1  active-low start 2, to `in1_reg` bit 6
- `busy`  out  1  high whenever the state is not IDLE

## Operation
- **Frame tick:** one-cycle strobe on each rising edge of `vblank`. `vblank` is registered once; tick = `vblank & ~vblank_q`.
- **States:** IDLE, COIN, GAP, START, RELEASE.
- **IDLE:**
  - `start2_req` → COIN with `credits_left = 2`, `sel = 2`.
  - Otherwise `start1_req` → COIN with `credits_left = 1`, `sel = 1`.
  - Simultaneous requests: 2P wins.
- **COIN:** `coin_n = 0`. After `COIN_FRAMES` ticks seen in the state → GAP, and `credits_left` decrements.
- **GAP:** all outputs inactive. After `GAP_FRAMES` ticks:
  - `credits_left != 0` → COIN.
  - Otherwise → START.
- **START:** `start1_n = 0` if `sel == 1`, else `start2_n = 0`. After `START_FRAMES` ticks → RELEASE.
- **RELEASE:** wait until both requests are low, then → IDLE. This prevents auto-repeat while a button is held.
- **Frame counter:**
  - Cleared on every state entry; increments on each tick.
  - Exit fires on the cycle where a tick arrives with `count == N-1`.
  - Width = `$clog2(max(COIN_FRAMES, GAP_FRAMES, START_FRAMES) + 1)`.
- **Request handling:** requests are ignored in every state except IDLE and RELEASE.
- **Reset mid-sequence:** aborts with no partial pulse. All outputs go inactive immediately (async), and the state returns to IDLE.
- **Reset values:** `coin_n = 1`, `start1_n = 1`, `start2_n = 1`, `busy = 0`, state IDLE, counters 0, `sel = 1`.

## Timing
- All outputs are registered and decoded from the next-state value, so they change on the same edge as the state.
- A request high before edge *t* gives the COIN state with `coin_n = 0` and `busy = 1` after edge *t*: one-cycle latency.
- Phase length is measured in ticks, not frames.
  - The first COIN phase lasts (`COIN_FRAMES - 1`, `COIN_FRAMES`] frames, depending on the request's phase relative to VBLANK.
  - Every later phase starts on a tick edge, so it is exactly N frames.
- A tick on the exit cycle is consumed by the old state, not counted in the new one.
- `vblank` held high or low gives no ticks, and the FSM stalls in its current state.

## Configuration
- **`COIN_SEQ_DIRECT_COIN_EN` defined:**
  - Adds input `coin_req` (1 bit, active-high).
  - In IDLE, `coin_req` with no start request → COIN with `credits_left = 1` and a `no_start` flag set.
  - After its GAP, a `no_start` sequence goes to RELEASE instead of START.
  - Priority in IDLE: start2 > start1 > coin.
- **Undefined:** the port is absent, no flag is implemented, and credits are only generated by start requests.

## Structure
- Shared package `coin_seq_pkg`: state enum `coin_seq_state_t` (IDLE, COIN, GAP, START, RELEASE) and the default frame-count localparams.
- One natural sub-module: `vblank_tick`, a rising-edge strobe generator. It can be reused by other per-frame logic.
- The FSM, frame counter and credit counter stay in the top.

## Test plan
Defaults apply unless stated; VBLANK period is 20 clocks in the bench.
- **Reset and idle:** hold `RESET_N = 0`, then release with no requests → `coin_n`/`start1_n`/`start2_n` = 1 and `busy = 0` for 10 frames.
- **1P start:** pulse `start1_req` for 1 clock → `coin_n` low for ≤3 frames, 6 frames gap, `start1_n` low exactly 3 frames, `start2_n` never low, `busy` falls the cycle after the sequence ends.
- **2P start:** `start2_req` → two `coin_n` pulses, each followed by a 6-frame gap, then `start2_n` low exactly 3 frames.
- **Simultaneous and held requests:**
  - `start1_req` and `start2_req` in the same cycle → 2P sequence.
  - Holding `start1_req` high for 40 frames → exactly one sequence; the FSM stays in RELEASE until release.
- **Reset mid-sequence:** assert `RESET_N = 0` during the second COIN of a 2P sequence → `coin_n = 1` with no clock edge needed. After release, the state is IDLE and no START occurs.
- **With `COIN_SEQ_DIRECT_COIN_EN`:** pulse `coin_req` → one coin pulse and 6-frame gap, no start pulse, `busy = 0` afterwards.
